// File: rtl/scr_port_arbiter.sv
// scr_port_arbiter: single-port screen RAM arbiter for display reads, command writes and host accesses.
// Build option SCR_ARB_ROUND_ROBIN_EN: round-robin cmd/host arbitration (default: cmd beats host).
module scr_port_arbiter #(
   parameter int         ADDR_W        = 16,
   parameter int         RAM_LAT       = 1,
   parameter logic [3:0] HOST_MAX_WAIT = 4'd15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic              disp_rvalid,
   input  logic              cmd_req,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [7:0]        cmd_wdata,
   output logic              cmd_gnt,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [7:0]        host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [7:0]        rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_data,
   output logic              ram_wren,
   input  logic [7:0]        ram_q,
   output logic              busy
);
   logic [3:0]       wait_cnt;
   logic [RAM_LAT:0] tag_disp, tag_host;
   logic             host_starved, host_pick;
`ifdef SCR_ARB_ROUND_ROBIN_EN
   logic rr_host;
   assign host_pick = host_req && (!cmd_req || rr_host);
   always_ff @(posedge clk or negedge rst)
      if (!rst) rr_host <= 1'b0;
      else if (cmd_gnt || host_gnt) rr_host <= cmd_gnt;
`else
   assign host_pick = host_req && !cmd_req;
`endif
   assign host_starved = host_req && (wait_cnt == HOST_MAX_WAIT);
   // grants are gated by rst so they read 0 throughout reset
   assign disp_gnt = rst && disp_req && !host_starved;
   assign host_gnt = rst && host_req && (host_starved || (!disp_req && host_pick));
   assign cmd_gnt  = rst && cmd_req && !disp_req && !host_starved && !host_pick;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wait_cnt <= 4'd0;
         tag_disp <= '0;
         tag_host <= '0;
         ram_addr <= '0;
         ram_data <= 8'h00;
         ram_wren <= 1'b0;
      end else begin
         wait_cnt <= (host_req && !host_gnt) ? wait_cnt + {3'b000, wait_cnt != HOST_MAX_WAIT} : 4'd0;
         tag_disp <= {tag_disp[RAM_LAT-1:0], disp_gnt};
         tag_host <= {tag_host[RAM_LAT-1:0], host_gnt && !host_we};
         ram_addr <= disp_gnt ? disp_addr : cmd_gnt ? cmd_addr : host_gnt ? host_addr : ram_addr;
         ram_data <= cmd_gnt ? cmd_wdata : host_gnt ? host_wdata : ram_data;
         ram_wren <= cmd_gnt || (host_gnt && host_we);
      end
   assign disp_rvalid = tag_disp[RAM_LAT];
   assign host_rvalid = tag_host[RAM_LAT];
   assign busy        = |{tag_disp, tag_host};
   assign rdata       = (disp_rvalid || host_rvalid) ? ram_q : 8'h00;
endmodule

// File: tb/tb_scr_port_arbiter.sv
// tb_scr_port_arbiter: directed self-checking bench for scr_port_arbiter (RAM_LAT=1, HOST_MAX_WAIT=15).
module tb_scr_port_arbiter;
   logic        clk = 1'b0, rst = 1'b0;
   logic        disp_req = 0, cmd_req = 0, host_req = 0, host_we = 0;
   logic [15:0] disp_addr = 0, cmd_addr = 0, host_addr = 0;
   logic [7:0]  cmd_wdata = 0, host_wdata = 0, ram_q = 8'hFF;
   logic        disp_gnt, disp_rvalid, cmd_gnt, host_gnt, host_rvalid, ram_wren, busy;
   logic [7:0]  rdata, ram_data;
   logic [15:0] ram_addr;
   int          n_cmp = 0, n_err = 0;

   scr_port_arbiter dut (
      .clk(clk), .rst(rst),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt), .disp_rvalid(disp_rvalid),
      .cmd_req(cmd_req), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_gnt(cmd_gnt),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid), .rdata(rdata),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q), .busy(busy)
   );

   always #5 clk = ~clk;

   // each cycle: inputs change at the falling edge, outputs are sampled 1 ns later
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic test_reset();
      next_cycle();
      disp_req = 1; cmd_req = 1; host_req = 1;
      #1;
      n_cmp++; if (disp_gnt !== 1'b0) begin n_err++; $display("FAIL rst_disp_gnt: got %b want 0", disp_gnt); end
      n_cmp++; if (cmd_gnt !== 1'b0) begin n_err++; $display("FAIL rst_cmd_gnt: got %b want 0", cmd_gnt); end
      n_cmp++; if (host_gnt !== 1'b0) begin n_err++; $display("FAIL rst_host_gnt: got %b want 0", host_gnt); end
      n_cmp++; if ({ram_wren, busy, disp_rvalid, host_rvalid} !== 4'b0) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {ram_wren, busy, disp_rvalid, host_rvalid}); end
      n_cmp++; if ({ram_addr, ram_data, rdata} !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", {ram_addr, ram_data, rdata}); end
      next_cycle();
      disp_req = 0; cmd_req = 0; host_req = 0; rst = 1;
      next_cycle();
   endtask

   task automatic test_disp_read();
      next_cycle();
      ram_q = 8'h5A; disp_req = 1; disp_addr = 16'h0100;
      #1;
      n_cmp++; if ({disp_gnt, cmd_gnt, host_gnt} !== 3'b100) begin n_err++; $display("FAIL disp_gnt: got %b want 100", {disp_gnt, cmd_gnt, host_gnt}); end
      next_cycle();
      disp_req = 0; disp_addr = 16'hFFFF;
      #1;
      n_cmp++; if (ram_addr !== 16'h0100) begin n_err++; $display("FAIL disp_ram_addr: got %h want 0100", ram_addr); end
      n_cmp++; if (ram_wren !== 1'b0) begin n_err++; $display("FAIL disp_ram_wren: got %b want 0", ram_wren); end
      n_cmp++; if ({disp_rvalid, busy, rdata} !== {1'b0, 1'b1, 8'h00}) begin n_err++; $display("FAIL disp_c1: got %b %b %h want 0 1 00", disp_rvalid, busy, rdata); end
      next_cycle();
      #1;
      n_cmp++; if ({disp_rvalid, host_rvalid, rdata} !== {2'b10, 8'h5A}) begin n_err++; $display("FAIL disp_rvalid: got %b %b %h want 1 0 5a", disp_rvalid, host_rvalid, rdata); end
      next_cycle();
      #1;
      n_cmp++; if ({disp_rvalid, busy, rdata} !== 10'b0) begin n_err++; $display("FAIL disp_c3: got %b %b %h want 0 0 00", disp_rvalid, busy, rdata); end
   endtask

   task automatic test_host_write();
      next_cycle();
      host_req = 1; host_we = 1; host_addr = 16'h1234; host_wdata = 8'hA5;
      #1;
      n_cmp++; if ({disp_gnt, cmd_gnt, host_gnt} !== 3'b001) begin n_err++; $display("FAIL hw_gnt: got %b want 001", {disp_gnt, cmd_gnt, host_gnt}); end
      next_cycle();
      host_req = 0; host_we = 0;
      #1;
      n_cmp++; if ({ram_wren, ram_addr, ram_data} !== {1'b1, 16'h1234, 8'hA5}) begin n_err++; $display("FAIL hw_ram: got %b %h %h want 1 1234 a5", ram_wren, ram_addr, ram_data); end
      n_cmp++; if ({host_rvalid, busy} !== 2'b00) begin n_err++; $display("FAIL hw_busy: got %b want 00", {host_rvalid, busy}); end
      next_cycle();
      #1;
      n_cmp++; if ({ram_wren, ram_addr, host_rvalid} !== {1'b0, 16'h1234, 1'b0}) begin n_err++; $display("FAIL hw_after: got %b %h %b want 0 1234 0", ram_wren, ram_addr, host_rvalid); end
   endtask

   task automatic test_cmd_write();
      next_cycle();
      cmd_req = 1; cmd_addr = 16'h0042; cmd_wdata = 8'h77;
      #1;
      n_cmp++; if ({disp_gnt, cmd_gnt, host_gnt} !== 3'b010) begin n_err++; $display("FAIL cw_gnt: got %b want 010", {disp_gnt, cmd_gnt, host_gnt}); end
      next_cycle();
      cmd_req = 0;
      #1;
      n_cmp++; if ({ram_wren, ram_addr, ram_data, busy} !== {1'b1, 16'h0042, 8'h77, 1'b0}) begin n_err++; $display("FAIL cw_ram: got %b %h %h %b want 1 0042 77 0", ram_wren, ram_addr, ram_data, busy); end
   endtask

   task automatic test_starvation();
      next_cycle();
      ram_q = 8'hC3; disp_req = 1; cmd_req = 1; host_req = 1; host_we = 0;
      for (int k = 0; k <= 16; k++) begin
         #1;
         n_cmp++; if ({disp_gnt, cmd_gnt, host_gnt} !== ((k == 15) ? 3'b001 : 3'b100)) begin n_err++; $display("FAIL starve_c%0d: got %b want %b", k, {disp_gnt, cmd_gnt, host_gnt}, (k == 15) ? 3'b001 : 3'b100); end
         next_cycle();
      end
      disp_req = 0; cmd_req = 0; host_req = 0;
      #1;
      n_cmp++; if ({host_rvalid, disp_rvalid, rdata} !== {2'b10, 8'hC3}) begin n_err++; $display("FAIL starve_host_ret: got %b %b %h want 1 0 c3", host_rvalid, disp_rvalid, rdata); end
      next_cycle();
      #1;
      n_cmp++; if ({host_rvalid, disp_rvalid} !== 2'b01) begin n_err++; $display("FAIL starve_disp_ret: got %b want 01", {host_rvalid, disp_rvalid}); end
      next_cycle();
   endtask

   task automatic test_cmd_host_contention();
      logic exp_host;
      next_cycle();
      cmd_req = 1; host_req = 1; host_we = 0;
      for (int k = 0; k < 6; k++) begin
`ifdef SCR_ARB_ROUND_ROBIN_EN
         exp_host = (k % 2) == 1;
`else
         exp_host = 1'b0;
`endif
         #1;
         n_cmp++; if ({disp_gnt, cmd_gnt, host_gnt} !== {1'b0, !exp_host, exp_host}) begin n_err++; $display("FAIL contend_c%0d: got %b want %b", k, {disp_gnt, cmd_gnt, host_gnt}, {1'b0, !exp_host, exp_host}); end
         next_cycle();
      end
      cmd_req = 0; host_req = 0;
      repeat (3) next_cycle();
   endtask

   task automatic test_reset_inflight();
      next_cycle();
      ram_q = 8'h99; host_req = 1; host_we = 0; host_addr = 16'h0777;
      #1;
      n_cmp++; if (host_gnt !== 1'b1) begin n_err++; $display("FAIL rif_gnt: got %b want 1", host_gnt); end
      next_cycle();
      rst = 0;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if ({host_gnt, host_rvalid, busy, ram_wren, ram_addr, ram_data, rdata} !== 36'h0) begin n_err++; $display("FAIL rif_c%0d: got %h want 0", k, {host_gnt, host_rvalid, busy, ram_wren, ram_addr, ram_data, rdata}); end
         next_cycle();
         #1;
      end
      host_req = 0;
      next_cycle();
      rst = 1;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if ({host_rvalid, busy, rdata} !== 10'h0) begin n_err++; $display("FAIL rif_post_c%0d: got %b %b %h want 0 0 00", k, host_rvalid, busy, rdata); end
         next_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_disp_read();
      test_host_write();
      test_cmd_write();
      test_starvation();
      test_cmd_host_contention();
      test_reset_inflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
